// File: rtl/edit_pkg.sv
// -----------------------------------------------------------------------------
// edit_pkg
// Shared types and constants for the edit scheduler:
//   - edit_mode_e : edit mode carried with each command
//   - BTN_*       : bit positions within the {c,d,u,r,l} button vectors
//   - state_e     : scheduler FSM states
//   - dir_decode  : maps a pair of opposing buttons to a signed -1/0/+1 step
// -----------------------------------------------------------------------------
package edit_pkg;

  typedef enum logic [1:0] {
    MODE_MOVE   = 2'd0,
    MODE_RESIZE = 2'd1,
    MODE_ADDREM = 2'd2,
    MODE_COLOR  = 2'd3
  } edit_mode_e;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;
  localparam int BTN_C = 4;
  localparam int BTN_W = 5;

  localparam int HOLD_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ISSUE   = 2'd2
  } state_e;

  // Two's-complement encodings of a 2-bit signed direction.
  localparam logic [1:0] DIR_ZERO = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b11;

  // Opposing buttons cancel: only a lone press yields a direction.
  function automatic logic [1:0] dir_decode(input logic pos, input logic neg);
    logic [1:0] dir;
    case ({pos, neg})
      2'b10:   dir = DIR_POS;
      2'b01:   dir = DIR_NEG;
      default: dir = DIR_ZERO;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/hold_ramp.sv
// -----------------------------------------------------------------------------
// hold_ramp
// Auto-repeat acceleration: counts consecutive captures with a held direction
// and decodes the step magnitude (1, then 2 after RAMP1 holds, then 4 after
// RAMP2 holds). A change of edit mode restarts the ramp.
// Only instantiated when EDIT_AUTO_REPEAT_EN is defined.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   i_capture  in   scheduler is in its capture cycle
//   i_moving   in   a direction (dx or dy) is non-zero this capture
//   i_mode     in   current edit mode
//   o_step     out  step magnitude for this capture (combinational)
// -----------------------------------------------------------------------------
module hold_ramp
  import edit_pkg::*;
#(
  parameter int STEPW = 4,
  parameter int RAMP1 = 16,
  parameter int RAMP2 = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_capture,
  input  logic             i_moving,
  input  logic [1:0]       i_mode,
  output logic [STEPW-1:0] o_step
);

  localparam logic [31:0] LIM1 = 32'(RAMP1);
  localparam logic [31:0] LIM2 = 32'(RAMP2);

  logic [HOLD_W-1:0] r_cnt;
  logic [1:0]        r_prev_mode;
  logic              w_mode_chg;
  logic [31:0]       w_cnt_ext;

  assign w_mode_chg = (i_mode != r_prev_mode);
  assign w_cnt_ext  = 32'(r_cnt);

  // Step is decoded from the counter value before this capture's increment.
  // NOTE: o_step is assigned a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    o_step = STEPW'(1);
    if (!w_mode_chg) begin
      if (w_cnt_ext >= LIM2)      o_step = STEPW'(4);
      else if (w_cnt_ext >= LIM1) o_step = STEPW'(2);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_prev_mode <= '0;
    end else if (i_capture) begin
      r_prev_mode <= i_mode;
      if (w_mode_chg || !i_moving) r_cnt <= '0;
      else if (r_cnt != '1)        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/edit_scheduler.sv
// -----------------------------------------------------------------------------
// edit_scheduler
// Once per video frame, samples the held buttons and the presses latched since
// the previous frame, and offers one edit command to the shape register file
// over a valid/ready handshake.
//
// Optional feature: define EDIT_AUTO_REPEAT_EN to enable the hold-to-accelerate
// step ramp (hold_ramp). Without it cmd_step is always 1.
//
// Ports
//   clk        in   single clock
//   rst        in   synchronous active-high reset
//   frame      in   one-cycle pulse at start of vertical blanking
//   mode       in   edit mode (0 move, 1 resize/rotate, 2 add/remove, 3 color)
//   btn        in   debounced button levels {c,d,u,r,l}
//   btn_dn     in   one-cycle press pulses, same ordering as btn
//   cmd_ready  in   shape register file accepts the command
//   cmd_valid  out  command offered
//   cmd_mode   out  mode captured with the command
//   cmd_dx     out  signed x direction (-1/0/+1)
//   cmd_dy     out  signed y direction (-1/0/+1)
//   cmd_step   out  magnitude per unit direction
//   cmd_press  out  presses latched since the previous capture
//   overrun    out  sticky: a frame arrived while a command was still pending
// -----------------------------------------------------------------------------
module edit_scheduler
  import edit_pkg::*;
#(
  parameter int STEPW = 4,
  parameter int RAMP1 = 16,
  parameter int RAMP2 = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic [1:0]       mode,
  input  logic [4:0]       btn,
  input  logic [4:0]       btn_dn,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [1:0]       cmd_mode,
  output logic [1:0]       cmd_dx,
  output logic [1:0]       cmd_dy,
  output logic [STEPW-1:0] cmd_step,
  output logic [4:0]       cmd_press,
  output logic             overrun
);

  state_e             r_state;
  logic [BTN_W-1:0]   r_press;
  logic               r_cmd_valid;
  edit_mode_e         r_cmd_mode;
  logic [1:0]         r_cmd_dx;
  logic [1:0]         r_cmd_dy;
  logic [STEPW-1:0]   r_cmd_step;
  logic [BTN_W-1:0]   r_cmd_press;
  logic               r_overrun;

  logic [1:0]         w_dx;
  logic [1:0]         w_dy;
  logic               w_moving;
  logic               w_nonempty;
  logic               w_capture;
  logic [STEPW-1:0]   w_step;
  logic               w_unused;

  assign w_dx       = dir_decode(btn[BTN_R], btn[BTN_L]);
  assign w_dy       = dir_decode(btn[BTN_D], btn[BTN_U]);
  assign w_moving   = (w_dx != DIR_ZERO) || (w_dy != DIR_ZERO);
  assign w_nonempty = w_moving || (r_press != '0);
  assign w_capture  = (r_state == ST_CAPTURE);

`ifdef EDIT_AUTO_REPEAT_EN
  hold_ramp #(
    .STEPW (STEPW),
    .RAMP1 (RAMP1),
    .RAMP2 (RAMP2)
  ) u_hold_ramp (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_moving  (w_moving),
    .i_mode    (mode),
    .o_step    (w_step)
  );
  // The centre button level carries no direction; only its press is used.
  assign w_unused = btn[BTN_C];
`else
  assign w_step   = STEPW'(1);
  assign w_unused = btn[BTN_C] ^ (RAMP1 > RAMP2);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_press     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_mode  <= MODE_MOVE;
      r_cmd_dx    <= '0;
      r_cmd_dy    <= '0;
      r_cmd_step  <= '0;
      r_cmd_press <= '0;
      r_overrun   <= 1'b0;
    end else begin
      // The latch is emptied by the capture, but a press arriving in that
      // same cycle is kept for the next frame.
      r_press <= (w_capture ? '0 : r_press) | btn_dn;

      case (r_state)
        ST_IDLE: begin
          if (frame) r_state <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          // A frame here is ignored: the capture is already under way.
          r_cmd_mode  <= edit_mode_e'(mode);
          r_cmd_dx    <= w_dx;
          r_cmd_dy    <= w_dy;
          r_cmd_step  <= w_step;
          r_cmd_press <= r_press;
          if (w_nonempty) begin
            r_cmd_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end else begin
            r_state     <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          if (frame) r_overrun <= 1'b1;
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_mode  = r_cmd_mode;
  assign cmd_dx    = r_cmd_dx;
  assign cmd_dy    = r_cmd_dy;
  assign cmd_step  = r_cmd_step;
  assign cmd_press = r_cmd_press;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_edit_scheduler.sv
// -----------------------------------------------------------------------------
// tb_edit_scheduler
// Directed stimulus for edit_scheduler. Each command expected to transfer is
// pushed into a scoreboard queue; an independent monitor pops and compares on
// every valid&ready handshake. Timing, overrun and reset behaviour are checked
// inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_edit_scheduler;
  import edit_pkg::*;

  localparam int STEPW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame;
  logic [1:0]       mode;
  logic [4:0]       btn;
  logic [4:0]       btn_dn;
  logic             cmd_ready;
  logic             cmd_valid;
  logic [1:0]       cmd_mode;
  logic [1:0]       cmd_dx;
  logic [1:0]       cmd_dy;
  logic [STEPW-1:0] cmd_step;
  logic [4:0]       cmd_press;
  logic             overrun;

  always #5 clk = ~clk;

  edit_scheduler #(
    .STEPW (STEPW),
    .RAMP1 (16),
    .RAMP2 (48)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame     (frame),
    .mode      (mode),
    .btn       (btn),
    .btn_dn    (btn_dn),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_mode  (cmd_mode),
    .cmd_dx    (cmd_dx),
    .cmd_dy    (cmd_dy),
    .cmd_step  (cmd_step),
    .cmd_press (cmd_press),
    .overrun   (overrun)
  );

  typedef struct {
    logic [1:0] mode;
    logic [1:0] dx;
    logic [1:0] dy;
    logic [3:0] step;
    logic [4:0] press;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Step expected for a given pre-increment hold count.
  function automatic logic [3:0] ramp_step(input int pre_cnt);
    logic [3:0] s;
    s = (pre_cnt < 16) ? 4'd1 : (pre_cnt < 48) ? 4'd2 : 4'd4;
`ifndef EDIT_AUTO_REPEAT_EN
    s = 4'd1;
`endif
    return s;
  endfunction

  task automatic push(input logic [1:0] m, input logic [1:0] dx, input logic [1:0] dy,
                      input logic [3:0] st, input logic [4:0] pr);
    exp_t e;
    e.mode  = m;
    e.dx    = dx;
    e.dy    = dy;
    e.step  = st;
    e.press = pr;
    sb_q.push_back(e);
  endtask

  // Frame from IDLE. dn_cap is pulsed on btn_dn during the capture cycle.
  task automatic pulse_frame(input logic [4:0] dn_cap, input logic exp_valid, input string name);
    @(posedge clk); #1 frame = 1'b1;
    @(posedge clk); #1 frame = 1'b0; btn_dn = dn_cap;
    @(negedge clk);
    check({name, "_valid_t1"}, 32'(cmd_valid), 32'(0));
    @(posedge clk); #1 btn_dn = 5'b0;
    @(negedge clk);
    check({name, "_valid_t2"}, 32'(cmd_valid), 32'(exp_valid));
    @(posedge clk); #1;
    @(negedge clk);
    if (cmd_ready && exp_valid)
      check({name, "_valid_drop"}, 32'(cmd_valid), 32'(0));
  endtask

  // Bare one-cycle frame pulse, used while a command is pending.
  task automatic raw_frame();
    @(posedge clk); #1 frame = 1'b1;
    @(posedge clk); #1 frame = 1'b0;
  endtask

  // Scoreboard monitor: compare on each handshake.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_cmd: got transfer dx=%0h dy=%0h expected none", cmd_dx, cmd_dy);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_mode",  32'(cmd_mode),  32'(mon_e.mode));
        check("sb_dx",    32'(cmd_dx),    32'(mon_e.dx));
        check("sb_dy",    32'(cmd_dy),    32'(mon_e.dy));
        check("sb_step",  32'(cmd_step),  32'(mon_e.step));
        check("sb_press", 32'(cmd_press), 32'(mon_e.press));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; frame = 1'b0; mode = 2'd0; btn = 5'b0; btn_dn = 5'b0; cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid",   32'(cmd_valid), 32'(0));
    check("rst_overrun", 32'(overrun),   32'(0));
    check("rst_press",   32'(cmd_press), 32'(0));
    check("rst_step",    32'(cmd_step),  32'(0));
    check("rst_dx",      32'(cmd_dx),    32'(0));
    check("rst_state",   32'(dut.r_state), 32'(ST_IDLE));
    rst = 1'b0;

    // Hold r for 20 frames: ramp reaches step 2 on frame 17.
    btn = 5'b00010;
    for (int k = 1; k <= 20; k++) begin
      push(2'd0, 2'b01, 2'b00, ramp_step(k - 1), 5'b0);
      pulse_frame(5'b0, 1'b1, "hold_r");
    end

    // l and r together cancel: empty command, back to IDLE, counter cleared.
    btn = 5'b00011;
    pulse_frame(5'b0, 1'b0, "lr_cancel");
    check("lr_state", 32'(dut.r_state), 32'(ST_IDLE));
`ifdef EDIT_AUTO_REPEAT_EN
    check("lr_cnt", 32'(dut.u_hold_ramp.r_cnt), 32'(0));
`endif

    // Press of c during the capture cycle defers to the next frame.
    btn = 5'b00010;
    push(2'd0, 2'b01, 2'b00, ramp_step(0), 5'b0);
    pulse_frame(5'b10000, 1'b1, "c_in_cap");
    push(2'd0, 2'b01, 2'b00, ramp_step(1), 5'b10000);
    pulse_frame(5'b0, 1'b1, "c_next");

    // Back-pressure with u held: outputs frozen, overrun set by 2nd frame.
    btn = 5'b00100;
    cmd_ready = 1'b0;
    push(2'd0, 2'b00, 2'b11, ramp_step(2), 5'b0);
    pulse_frame(5'b0, 1'b1, "bp_f1");
    check("bp_ovr_f1", 32'(overrun), 32'(0));
    for (int f = 2; f <= 3; f++) begin
      raw_frame();
      @(negedge clk);
      check("bp_ovr",   32'(overrun),   32'(1));
      check("bp_valid", 32'(cmd_valid), 32'(1));
      check("bp_dx",    32'(cmd_dx),    32'(2'b00));
      check("bp_dy",    32'(cmd_dy),    32'(2'b11));
      check("bp_step",  32'(cmd_step),  32'(ramp_step(2)));
      check("bp_press", 32'(cmd_press), 32'(0));
      check("bp_state", 32'(dut.r_state), 32'(ST_ISSUE));
    end
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drop",     32'(cmd_valid), 32'(0));
    check("bp_ovr_kept", 32'(overrun),   32'(1));

    // Clear the ramp, hold d 60 frames in mode 0, then switch to mode 1.
    btn = 5'b00011;
    pulse_frame(5'b0, 1'b0, "clr");
    btn = 5'b01000;
    for (int k = 1; k <= 60; k++) begin
      push(2'd0, 2'b00, 2'b01, ramp_step(k - 1), 5'b0);
      pulse_frame(5'b0, 1'b1, "hold_d");
    end
    mode = 2'd1;
    push(2'd1, 2'b00, 2'b01, 4'd1, 5'b0);
    pulse_frame(5'b0, 1'b1, "mode_sw");
    push(2'd1, 2'b00, 2'b01, ramp_step(0), 5'b0);
    pulse_frame(5'b0, 1'b1, "mode_sw2");

    // Reset while a command is pending drops it and any latched presses.
    btn = 5'b0;
    cmd_ready = 1'b0;
    @(posedge clk); #1 btn_dn = 5'b00010;
    @(posedge clk); #1 btn_dn = 5'b0;
    pulse_frame(5'b0, 1'b1, "rst_pend");
    check("rst_pend_press", 32'(cmd_press), 32'(5'b00010));
    @(posedge clk); #1 btn_dn = 5'b00001;
    @(posedge clk); #1 btn_dn = 5'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid",   32'(cmd_valid), 32'(0));
    check("rst_mid_overrun", 32'(overrun),   32'(0));
    check("rst_mid_press",   32'(cmd_press), 32'(0));
    rst = 1'b0;
    cmd_ready = 1'b1;
    pulse_frame(5'b0, 1'b0, "post_rst");
    check("post_rst_press", 32'(cmd_press), 32'(0));

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/edit_scheduler.md
EDIT_SCHEDULER -- requirements
Module: edit_scheduler

Interface
REQ-001 SHALL have parameter STEPW, default 4, width of cmd_step.
REQ-002 SHALL have parameter RAMP1, default 16, hold frames before step becomes 2.
REQ-003 SHALL have parameter RAMP2, default 48, hold frames before step becomes 4.
REQ-004 SHALL have port clk  in  1  single clock.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port frame  in  1  one-cycle pulse at start of vertical blanking.
REQ-007 SHALL have port mode  in  2  edit mode (0 move, 1 resize/rotate, 2 add/remove, 3 color).
REQ-008 SHALL have port btn  in  5  debounced levels {c,d,u,r,l}.
REQ-009 SHALL have port btn_dn  in  5  one-cycle press pulses, same ordering as btn.
REQ-010 SHALL have port cmd_ready  in  1  shape-register-file accepts command.
REQ-011 SHALL have port cmd_valid  out  1  command offered.
REQ-012 SHALL have port cmd_mode  out  2  mode captured for this command.
REQ-013 SHALL have ports cmd_dx and cmd_dy  out  2 each  signed direction, -1/0/+1.
REQ-014 SHALL have port cmd_step  out  STEPW  magnitude per unit direction.
REQ-015 SHALL have port cmd_press  out  5  presses latched since previous capture.
REQ-016 SHALL have port overrun  out  1  sticky: frame arrived while a command was pending.

Function
REQ-017 SHALL implement states IDLE, CAPTURE, ISSUE; IDLE->CAPTURE on frame; CAPTURE->ISSUE if command non-empty, else ->IDLE; ISSUE->IDLE on cmd_valid&cmd_ready.
REQ-018 SHALL OR every btn_dn pulse into a 5-bit press latch in every state.
REQ-019 In CAPTURE, SHALL copy the latch to cmd_press and clear it; a btn_dn in that same cycle SHALL remain set in the latch for the next frame.
REQ-020 In CAPTURE, SHALL set cmd_dx = +1 for r only, -1 for l only, 0 for both or neither; cmd_dy = +1 for d only, -1 for u only, 0 otherwise.
REQ-021 Command non-empty SHALL mean cmd_dx!=0, cmd_dy!=0 or cmd_press!=0.
REQ-022 SHALL keep a 6-bit hold counter that, in CAPTURE, increments (saturating at 63) when dx|dy nonzero and clears to 0 otherwise.
REQ-023 cmd_step SHALL be 1 if the pre-increment counter < RAMP1, 2 if < RAMP2, else 4, zero-extended to STEPW.
REQ-024 If mode differs from the previously captured mode, the hold counter SHALL clear and cmd_step SHALL be 1.
REQ-025 cmd_valid SHALL assert the cycle after CAPTURE (frame at cycle t -> cmd_valid at t+2).
REQ-026 All cmd_* outputs SHALL hold stable while cmd_valid=1 and cmd_ready=0.
REQ-027 cmd_valid SHALL deassert the cycle after the transfer; cmd_ready while cmd_valid=0 SHALL be ignored.
REQ-028 A frame pulse in ISSUE SHALL set overrun and SHALL NOT start a capture; press latching continues.
REQ-029 A frame pulse in CAPTURE SHALL be ignored (not counted as overrun).

Reset
REQ-030 On rst SHALL force IDLE; cmd_valid, cmd_mode, cmd_dx, cmd_dy, cmd_step, cmd_press, overrun, press latch, hold counter, previous mode all 0.
REQ-031 rst during ISSUE SHALL drop the pending command without transfer.
REQ-032 overrun SHALL clear only on rst.

Configuration
REQ-033 Macro EDIT_AUTO_REPEAT_EN: when defined, REQ-022..024 ramp active; when undefined, hold counter absent, cmd_step constant 1, other behaviour unchanged.

Structure
REQ-034 Package edit_pkg SHALL hold the mode enum, button index constants (L=0,R=1,U=2,D=3,C=4) and the state enum.
REQ-035 Sub-module hold_ramp SHALL contain the hold counter and step decode, instantiated only under EDIT_AUTO_REPEAT_EN.

Verification
REQ-036 Hold r for 20 frames, cmd_ready=1 -> dx=+1 each frame; step 1 on frames 1-16, 2 on 17-20; cmd_valid exactly 2 cycles after each frame.
REQ-037 Hold l and r, no presses, frame -> no cmd_valid, state back to IDLE after 2 cycles, hold counter 0.
REQ-038 btn_dn[4] pulse in the CAPTURE cycle -> current cmd_press=0 (if no earlier press); next frame cmd_press=5'b10000.
REQ-039 cmd_ready=0 for 3 frames with u held -> outputs frozen, overrun=1 after 2nd frame; ready=1 -> single transfer, overrun stays 1.
REQ-040 Hold d 60 frames in mode 0 then switch mode to 1 -> step 4 before switch, step 1 on first capture after.
REQ-041 rst asserted while cmd_valid=1 -> next cycle cmd_valid=0, overrun=0, pending presses discarded.
